// File: rtl/mmu_pkg.sv
// Shared constants and types for the MMU translation path.
package mmu_pkg;

    localparam int VPN2_W = 19;
    localparam int PFN_W  = 20;
    localparam int ASID_W = 8;

    // TLB exception classes returned with each translation
    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_REFILL   = 2'd1;
    localparam logic [1:0] EXC_INVALID  = 2'd2;
    localparam logic [1:0] EXC_MODIFIED = 2'd3;

    // Top three vaddr bits selecting the unmapped kernel segments
    localparam logic [2:0] SEG_KSEG0 = 3'b100;
    localparam logic [2:0] SEG_KSEG1 = 3'b101;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/mmu_seg_decode.sv
// Combinational segment decode: classifies a virtual address and forms the
// direct-mapped physical address for kseg0/kseg1.
module mmu_seg_decode
    import mmu_pkg::*;
(
    input  logic [31:0] i_vaddr,
    output logic        o_kseg0,
    output logic        o_kseg1,
    output logic        o_mapped,
    output logic [31:0] o_unmapped_paddr,
    output logic        o_unmapped_uncached
);

    // Segment classification and unmapped address formation
    always_comb begin
        o_kseg0             = (i_vaddr[31:29] == SEG_KSEG0);
        o_kseg1             = (i_vaddr[31:29] == SEG_KSEG1);
        o_mapped            = !(o_kseg0 || o_kseg1);
        o_unmapped_paddr    = {3'b000, i_vaddr[28:0]};
        o_unmapped_uncached = o_kseg1;
    end

endmodule

// File: rtl/mmu_lookup_arbiter.sv
// Arbitrates the single TLB search port between fetch and data translation
// requesters, sequences the lookup and returns the result on a valid/ready
// response channel to the requester that owns the transaction.
module mmu_lookup_arbiter
    import mmu_pkg::*;
#(
    parameter int TLB = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic [ASID_W-1:0] asid,

    input  logic              inst_req_valid,
    output logic              inst_req_ready,
    input  logic [31:0]       inst_vaddr,
    output logic              inst_resp_valid,
    input  logic              inst_resp_ready,
    output logic [31:0]       inst_paddr,
    output logic              inst_uncached,
    output logic [1:0]        inst_exc,

    input  logic              data_req_valid,
    output logic              data_req_ready,
    input  logic [31:0]       data_vaddr,
    input  logic              data_is_store,
    output logic              data_resp_valid,
    input  logic              data_resp_ready,
    output logic [31:0]       data_paddr,
    output logic              data_uncached,
    output logic [1:0]        data_exc,

    output logic [VPN2_W-1:0] s_vpn2,
    output logic              s_odd_page,
    output logic [ASID_W-1:0] s_asid,
    input  logic              s_found,
    input  logic [PFN_W-1:0]  s_pfn,
    input  logic [2:0]        s_c,
    input  logic              s_v,
    input  logic              s_d
);

    state_e            r_state;
    state_e            w_next_state;
    owner_e            r_owner;
    owner_e            r_last_grant;
    logic [31:0]       r_vaddr;
    logic              r_is_store;
    logic [ASID_W-1:0] r_asid;
    logic [31:0]       r_paddr;
    logic              r_uncached;
    logic [1:0]        r_exc;

    logic              w_grant_inst;
    logic              w_grant_data;
    logic              w_accept;
    logic [31:0]       w_req_vaddr;
    logic              w_kseg0;
    logic              w_kseg1;
    logic              w_mapped;
    logic [31:0]       w_unmapped_paddr;
    logic              w_unmapped_uncached;
    logic [31:0]       w_tlb_paddr;
    logic              w_tlb_uncached;
    logic [1:0]        w_tlb_exc;

    mmu_seg_decode u_seg_decode (
        .i_vaddr             (w_req_vaddr),
        .o_kseg0             (w_kseg0),
        .o_kseg1             (w_kseg1),
        .o_mapped            (w_mapped),
        .o_unmapped_paddr    (w_unmapped_paddr),
        .o_unmapped_uncached (w_unmapped_uncached)
    );

    // Round-robin grant: a lone requester wins, a tie goes to whoever did not win last
    always_comb begin
        w_grant_inst = inst_req_valid && (!data_req_valid || (r_last_grant == OWNER_DATA));
        w_grant_data = data_req_valid && !w_grant_inst;
        w_accept     = (r_state == S_IDLE) && !flush && (inst_req_valid || data_req_valid);
        w_req_vaddr  = w_grant_inst ? inst_vaddr : data_vaddr;
    end

    // Translation result from the TLB hit data, with exception priority refill > invalid > modified
    always_comb begin
        w_tlb_paddr    = r_vaddr;
        w_tlb_uncached = 1'b0;
        w_tlb_exc      = EXC_NONE;
        if (TLB != 0) begin
            w_tlb_paddr    = {s_pfn, r_vaddr[11:0]};
            w_tlb_uncached = (s_c != 3'd3);
            if (!s_found)
                w_tlb_exc = EXC_REFILL;
            else if (!s_v)
                w_tlb_exc = EXC_INVALID;
            else if (r_is_store && !s_d)
                w_tlb_exc = EXC_MODIFIED;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state, handshake and TLB search outputs
    always_comb begin
        w_next_state    = r_state;
        inst_req_ready  = 1'b0;
        data_req_ready  = 1'b0;
        inst_resp_valid = 1'b0;
        data_resp_valid = 1'b0;
        s_vpn2          = '0;
        s_odd_page      = 1'b0;
        s_asid          = '0;
        case (r_state)
            S_IDLE: begin
                inst_req_ready = !flush && w_grant_inst;
                data_req_ready = !flush && w_grant_data;
                if (w_accept)
                    w_next_state = w_mapped ? S_LOOKUP : S_RESP;
            end
            S_LOOKUP: begin
                if (TLB != 0) begin
                    s_vpn2     = r_vaddr[31:13];
                    s_odd_page = r_vaddr[12];
                    s_asid     = r_asid;
                end
                w_next_state = S_RESP;
            end
            S_RESP: begin
                inst_resp_valid = (r_owner == OWNER_INST);
                data_resp_valid = (r_owner == OWNER_DATA);
                if ((inst_resp_valid && inst_resp_ready) || (data_resp_valid && data_resp_ready))
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        // flush overrides everything, including a same-cycle response handshake
        if (flush)
            w_next_state = S_IDLE;
    end

    // Request capture on accept and result capture (unmapped on accept, mapped after lookup)
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_owner      <= OWNER_INST;
            r_last_grant <= OWNER_DATA;
            r_vaddr      <= '0;
            r_is_store   <= 1'b0;
            r_asid       <= '0;
            r_paddr      <= '0;
            r_uncached   <= 1'b0;
            r_exc        <= EXC_NONE;
        end else if (w_accept) begin
            r_owner      <= w_grant_inst ? OWNER_INST : OWNER_DATA;
            r_last_grant <= w_grant_inst ? OWNER_INST : OWNER_DATA;
            r_vaddr      <= w_req_vaddr;
            r_is_store   <= w_grant_data && data_is_store;
            r_asid       <= asid;
            if (w_kseg0 || w_kseg1) begin
                r_paddr    <= w_unmapped_paddr;
                r_uncached <= w_unmapped_uncached;
                r_exc      <= EXC_NONE;
            end
        end else if (r_state == S_LOOKUP) begin
            r_paddr    <= w_tlb_paddr;
            r_uncached <= w_tlb_uncached;
            r_exc      <= w_tlb_exc;
        end
    end

    // Both result channels present the same held registers; only the owner's valid is raised
    always_comb begin
        inst_paddr    = r_paddr;
        inst_uncached = r_uncached;
        inst_exc      = r_exc;
        data_paddr    = r_paddr;
        data_uncached = r_uncached;
        data_exc      = r_exc;
    end

endmodule

// File: tb/tb_mmu_lookup_arbiter.sv
// Directed self-checking bench for mmu_lookup_arbiter.
module tb_mmu_lookup_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  asid = '0;
    logic        inst_req_valid = 1'b0;
    logic        inst_req_ready;
    logic [31:0] inst_vaddr = '0;
    logic        inst_resp_valid;
    logic        inst_resp_ready = 1'b0;
    logic [31:0] inst_paddr;
    logic        inst_uncached;
    logic [1:0]  inst_exc;
    logic        data_req_valid = 1'b0;
    logic        data_req_ready;
    logic [31:0] data_vaddr = '0;
    logic        data_is_store = 1'b0;
    logic        data_resp_valid;
    logic        data_resp_ready = 1'b0;
    logic [31:0] data_paddr;
    logic        data_uncached;
    logic [1:0]  data_exc;
    logic [18:0] s_vpn2;
    logic        s_odd_page;
    logic [7:0]  s_asid;
    logic        s_found = 1'b0;
    logic [19:0] s_pfn = '0;
    logic [2:0]  s_c = '0;
    logic        s_v = 1'b0;
    logic        s_d = 1'b0;

    int checks = 0;
    int errors = 0;

    mmu_lookup_arbiter #(.TLB(1)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .asid(asid),
        .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
        .inst_vaddr(inst_vaddr), .inst_resp_valid(inst_resp_valid),
        .inst_resp_ready(inst_resp_ready), .inst_paddr(inst_paddr),
        .inst_uncached(inst_uncached), .inst_exc(inst_exc),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
        .data_vaddr(data_vaddr), .data_is_store(data_is_store),
        .data_resp_valid(data_resp_valid), .data_resp_ready(data_resp_ready),
        .data_paddr(data_paddr), .data_uncached(data_uncached), .data_exc(data_exc),
        .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
        .s_found(s_found), .s_pfn(s_pfn), .s_c(s_c), .s_v(s_v), .s_d(s_d)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        tick(); tick(); tick();
        checks++; if (inst_resp_valid !== 1'b0 || data_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b%b exp 00", inst_resp_valid, data_resp_valid); end
        checks++; if (inst_req_ready !== 1'b0 || data_req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b%b exp 00", inst_req_ready, data_req_ready); end
        checks++; if (inst_paddr !== 32'h0 || data_paddr !== 32'h0) begin errors++; $display("FAIL reset_paddr: got %h/%h exp 0", inst_paddr, data_paddr); end
        checks++; if (inst_exc !== 2'd0 || data_exc !== 2'd0 || inst_uncached !== 1'b0 || data_uncached !== 1'b0) begin errors++; $display("FAIL reset_exc_unc: got %0d/%0d %b%b exp 0", inst_exc, data_exc, inst_uncached, data_uncached); end
        checks++; if (s_vpn2 !== 19'h0 || s_odd_page !== 1'b0 || s_asid !== 8'h0) begin errors++; $display("FAIL reset_s_port: got %h %b %h exp 0", s_vpn2, s_odd_page, s_asid); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_unmapped_inst;
        inst_req_valid = 1'b1;
        inst_vaddr     = 32'h8000_1234;
        #1;
        checks++; if (inst_req_ready !== 1'b1) begin errors++; $display("FAIL kseg0_ready: got %b exp 1", inst_req_ready); end
        tick();
        inst_req_valid = 1'b0;
        checks++; if (inst_resp_valid !== 1'b1 || data_resp_valid !== 1'b0) begin errors++; $display("FAIL kseg0_valid_n1: got %b%b exp 10", inst_resp_valid, data_resp_valid); end
        checks++; if (inst_paddr !== 32'h0000_1234 || inst_uncached !== 1'b0 || inst_exc !== 2'd0) begin errors++; $display("FAIL kseg0_result: got %h %b %0d exp 00001234 0 0", inst_paddr, inst_uncached, inst_exc); end
        inst_resp_ready = 1'b1;
        tick();
        inst_resp_ready = 1'b0;
        checks++; if (inst_resp_valid !== 1'b0) begin errors++; $display("FAIL kseg0_drop: got %b exp 0", inst_resp_valid); end
    endtask

    task automatic test_unmapped_data;
        data_req_valid = 1'b1;
        data_vaddr     = 32'hA000_0040;
        data_is_store  = 1'b0;
        tick();
        data_req_valid = 1'b0;
        checks++; if (data_resp_valid !== 1'b1 || inst_resp_valid !== 1'b0) begin errors++; $display("FAIL kseg1_valid_n1: got %b%b exp 10", data_resp_valid, inst_resp_valid); end
        checks++; if (data_paddr !== 32'h0000_0040 || data_uncached !== 1'b1 || data_exc !== 2'd0) begin errors++; $display("FAIL kseg1_result: got %h %b %0d exp 00000040 1 0", data_paddr, data_uncached, data_exc); end
        data_resp_ready = 1'b1;
        tick();
        data_resp_ready = 1'b0;
    endtask

    task automatic test_mapped_lookup;
        asid = 8'h12;
        s_found = 1'b1; s_pfn = 20'h1F000; s_c = 3'd3; s_v = 1'b1; s_d = 1'b0;
        data_req_valid = 1'b1;
        data_vaddr     = 32'h0040_5678;
        data_is_store  = 1'b0;
        tick();
        data_req_valid = 1'b0;
        asid = 8'h34;
        #1;
        checks++; if (s_vpn2 !== 19'h00202 || s_odd_page !== 1'b1 || s_asid !== 8'h12) begin errors++; $display("FAIL lookup_search: got %h %b %h exp 00202 1 12", s_vpn2, s_odd_page, s_asid); end
        checks++; if (data_resp_valid !== 1'b0) begin errors++; $display("FAIL lookup_early_valid: got %b exp 0", data_resp_valid); end
        tick();
        checks++; if (data_resp_valid !== 1'b1) begin errors++; $display("FAIL lookup_valid_n2: got %b exp 1", data_resp_valid); end
        checks++; if (data_paddr !== 32'h1F00_0678 || data_uncached !== 1'b0 || data_exc !== 2'd0) begin errors++; $display("FAIL lookup_result: got %h %b %0d exp 1f000678 0 0", data_paddr, data_uncached, data_exc); end
        data_resp_ready = 1'b1;
        tick();
        data_resp_ready = 1'b0;
    endtask

    task automatic test_exceptions;
        logic        is_d[5]    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        st[5]      = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        fnd[5]     = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        vv[5]      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        dd[5]      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  cc[5]      = '{3'd3, 3'd3, 3'd3, 3'd2, 3'd3};
        logic [1:0]  exp_exc[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        logic        exp_unc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  obs_exc;
        logic [31:0] obs_pa;
        logic        obs_unc;
        logic        obs_v;
        logic        other_v;
        for (int i = 0; i < 5; i++) begin
            s_found = fnd[i]; s_pfn = 20'h12345; s_c = cc[i]; s_v = vv[i]; s_d = dd[i];
            if (is_d[i]) begin
                data_req_valid = 1'b1; data_vaddr = 32'h7FFF_EABC; data_is_store = st[i];
            end else begin
                inst_req_valid = 1'b1; inst_vaddr = 32'h7FFF_EABC;
            end
            tick();
            inst_req_valid = 1'b0; data_req_valid = 1'b0; data_is_store = 1'b0;
            tick();
            obs_exc = is_d[i] ? data_exc : inst_exc;
            obs_pa  = is_d[i] ? data_paddr : inst_paddr;
            obs_unc = is_d[i] ? data_uncached : inst_uncached;
            obs_v   = is_d[i] ? data_resp_valid : inst_resp_valid;
            other_v = is_d[i] ? inst_resp_valid : data_resp_valid;
            checks++; if (obs_v !== 1'b1 || other_v !== 1'b0) begin errors++; $display("FAIL exc%0d_valid: got owner=%b other=%b exp 1 0", i, obs_v, other_v); end
            checks++; if (obs_exc !== exp_exc[i]) begin errors++; $display("FAIL exc%0d_code: got %0d exp %0d", i, obs_exc, exp_exc[i]); end
            if (exp_exc[i] == 2'd0) begin
                checks++; if (obs_pa !== 32'h1234_5ABC || obs_unc !== exp_unc[i]) begin errors++; $display("FAIL exc%0d_result: got %h %b exp 12345abc %b", i, obs_pa, obs_unc, exp_unc[i]); end
            end
            inst_resp_ready = 1'b1; data_resp_ready = 1'b1;
            tick();
            inst_resp_ready = 1'b0; data_resp_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        s_found = 1'b1; s_pfn = 20'h0ABCD; s_c = 3'd3; s_v = 1'b1; s_d = 1'b1;
        data_req_valid = 1'b1; data_vaddr = 32'h0000_3123; data_is_store = 1'b1;
        tick();
        data_req_valid = 1'b0; data_is_store = 1'b0;
        tick();
        // requests and changing TLB data must not disturb the held result
        inst_req_valid = 1'b1; inst_vaddr = 32'h8000_0000;
        data_req_valid = 1'b1; data_vaddr = 32'h8000_0000;
        s_pfn = 20'hFFFFF; s_c = 3'd0; s_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (data_resp_valid !== 1'b1 || data_paddr !== 32'h0ABC_D123 || data_exc !== 2'd0 || data_uncached !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: got %b %h %0d %b exp 1 0abcd123 0 0", k, data_resp_valid, data_paddr, data_exc, data_uncached); end
            checks++; if (inst_req_ready !== 1'b0 || data_req_ready !== 1'b0) begin errors++; $display("FAIL bp_nogrant%0d: got %b%b exp 00", k, inst_req_ready, data_req_ready); end
            tick();
        end
        data_resp_ready = 1'b1;
        #1;
        checks++; if (inst_req_ready !== 1'b0 || data_req_ready !== 1'b0) begin errors++; $display("FAIL bp_handshake_nogrant: got %b%b exp 00", inst_req_ready, data_req_ready); end
        inst_req_valid = 1'b0; data_req_valid = 1'b0;
        tick();
        data_resp_ready = 1'b0;
        checks++; if (data_resp_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b exp 0", data_resp_valid); end
    endtask

    task automatic test_flush;
        s_found = 1'b1; s_pfn = 20'h00001; s_c = 3'd3; s_v = 1'b1; s_d = 1'b1;
        data_req_valid = 1'b1; data_vaddr = 32'h0000_2000; data_is_store = 1'b0;
        tick();
        data_req_valid = 1'b0;
        inst_req_valid = 1'b1; inst_vaddr = 32'h8000_0300;
        flush = 1'b1;
        #1;
        checks++; if (data_resp_valid !== 1'b0 || inst_req_ready !== 1'b0) begin errors++; $display("FAIL flush_lookup: got valid=%b rdy=%b exp 0 0", data_resp_valid, inst_req_ready); end
        tick();
        checks++; if (data_resp_valid !== 1'b0 || inst_req_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_block: got valid=%b rdy=%b exp 0 0", data_resp_valid, inst_req_ready); end
        flush = 1'b0;
        #1;
        checks++; if (inst_req_ready !== 1'b1) begin errors++; $display("FAIL flush_release_ready: got %b exp 1", inst_req_ready); end
        tick();
        inst_req_valid = 1'b0;
        checks++; if (inst_resp_valid !== 1'b1 || data_resp_valid !== 1'b0 || inst_paddr !== 32'h0000_0300) begin errors++; $display("FAIL flush_next_req: got %b%b %h exp 10 00000300", inst_resp_valid, data_resp_valid, inst_paddr); end
        // flush while a result is waiting discards it
        flush = 1'b1;
        inst_resp_ready = 1'b1;
        tick();
        flush = 1'b0;
        inst_resp_ready = 1'b0;
        checks++; if (inst_resp_valid !== 1'b0) begin errors++; $display("FAIL flush_resp: got %b exp 0", inst_resp_valid); end
    endtask

    task automatic test_back_to_back;
        // last grant was inst; reset must restore the first tie to inst
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        inst_req_valid = 1'b1; inst_vaddr = 32'h8000_0100;
        data_req_valid = 1'b1; data_vaddr = 32'h8000_0200; data_is_store = 1'b0;
        inst_resp_ready = 1'b1; data_resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic exp_i;
            exp_i = (k % 2 == 0);
            #1;
            checks++; if (inst_req_ready !== exp_i || data_req_ready !== !exp_i) begin errors++; $display("FAIL rr_grant%0d: got %b%b exp %b%b", k, inst_req_ready, data_req_ready, exp_i, !exp_i); end
            tick();
            checks++; if (inst_resp_valid !== exp_i || data_resp_valid !== !exp_i || data_paddr !== (exp_i ? 32'h0000_0100 : 32'h0000_0200)) begin errors++; $display("FAIL rr_resp%0d: got %b%b %h", k, inst_resp_valid, data_resp_valid, data_paddr); end
            tick();
        end
        inst_req_valid = 1'b0; data_req_valid = 1'b0;
        inst_resp_ready = 1'b0; data_resp_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_unmapped_inst();
        test_unmapped_data();
        test_mapped_lookup();
        test_exceptions();
        test_backpressure();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
